// File: rtl/if_pc_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_pc_queue_pkg                                                      |
// | Shared fetch-queue defaults and the fetch-group entry layout.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package if_pc_queue_pkg;

   localparam int IF_QUEUE_DEPTH    = 4;
   localparam int IF_FETCH_WIDTH    = 2;
   localparam int IF_ADDR_WIDTH     = 32;
   localparam int IF_EXCP_NUM_WIDTH = 4;

   // Reference layout of one queued fetch group at the default widths.
   // The queue itself keeps each field in its own parametrised array.
   typedef struct packed {
      logic [IF_ADDR_WIDTH-1:0]     pc;
      logic [IF_FETCH_WIDTH-1:0]    lane_mask;
      logic                         excp;
      logic [IF_EXCP_NUM_WIDTH-1:0] excp_num;
   } if_fetch_entry_t;

endpackage : if_pc_queue_pkg
`default_nettype wire

// File: rtl/if_lane_pc_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_lane_pc_expand                                                    |
// | Expands a fetch-group base PC into per-lane instruction PCs.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_lane_pc_expand #(
   parameter int FETCH_WIDTH = 2,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic [ADDR_WIDTH-1:0]             base_pc_i,
   input  logic [FETCH_WIDTH-1:0]            lane_mask_i,
   output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] lane_pc_o,
   output logic [FETCH_WIDTH-1:0]            lane_valid_o
);

   // Lane k sits 4*k bytes above the base; carry past the top bit wraps.
   for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
      assign lane_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH] = base_pc_i + ADDR_WIDTH'(4 * k);
   end

   assign lane_valid_o = lane_mask_i;

endmodule : if_lane_pc_expand
`default_nettype wire

// File: rtl/if_pc_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_pc_queue                                                          |
// | DEPTH-entry circular FIFO of fetch groups (PC, lane mask, exception) |
// | between the PC generator and the align/decode handoff, with squash.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_pc_queue
   import if_pc_queue_pkg::*;
#(
   parameter int DEPTH          = IF_QUEUE_DEPTH,
   parameter int FETCH_WIDTH    = IF_FETCH_WIDTH,
   parameter int ADDR_WIDTH     = IF_ADDR_WIDTH,
   parameter int EXCP_NUM_WIDTH = IF_EXCP_NUM_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push_valid,
   output logic                              push_ready,
   input  logic [ADDR_WIDTH-1:0]             push_pc,
   input  logic [FETCH_WIDTH-1:0]            push_lane_mask,
   input  logic                              push_excp,
   input  logic [EXCP_NUM_WIDTH-1:0]         push_excp_num,
   output logic                              pop_valid,
   input  logic                              pop_ready,
   output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] pop_pc,
   output logic [FETCH_WIDTH-1:0]            pop_lane_valid,
   output logic                              pop_excp,
   output logic [EXCP_NUM_WIDTH-1:0]         pop_excp_num,
   input  logic                              branch_flag_i,
   input  logic                              flush,
   input  logic                              excp_flush,
   input  logic                              ertn_flush,
   input  logic                              stall,
   output logic [$clog2(DEPTH):0]            count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   // A faulting group only ever presents its first instruction.
   localparam logic [FETCH_WIDTH-1:0] LANE0_ONLY = FETCH_WIDTH'(1);

   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;

   logic [ADDR_WIDTH-1:0]     pc_q       [DEPTH];
   logic [FETCH_WIDTH-1:0]    mask_q     [DEPTH];
   logic                      excp_q     [DEPTH];
   logic [EXCP_NUM_WIDTH-1:0] excp_num_q [DEPTH];

   logic                              empty, full, squash, push_fire, pop_fire;
   logic [IDX_W-1:0]                  rd_idx, wr_idx;
   logic [FETCH_WIDTH*ADDR_WIDTH-1:0] lane_pc;
   logic [FETCH_WIDTH-1:0]            lane_valid;

   assign rd_idx = rd_q[IDX_W-1:0];
   assign wr_idx = wr_q[IDX_W-1:0];
   assign empty  = (rd_q == wr_q);
   assign full   = (rd_idx == wr_idx) && (rd_q[IDX_W] != wr_q[IDX_W]);
   assign squash = branch_flag_i | flush | excp_flush | ertn_flush;

   // Ready and valid come only from registered pointers, never from the other side.
   assign push_ready = !full;
   assign pop_valid  = !empty;
   assign push_fire  = push_valid & push_ready;
   assign pop_fire   = pop_valid & pop_ready & !stall;
   assign count      = wr_q - rd_q;

   // Next pointers: squash clears both and swallows any same-cycle transfer.
   always_comb begin
      rd_d = rd_q;
      wr_d = wr_q;
      if (squash) begin
         rd_d = '0;
         wr_d = '0;
      end else begin
         if (push_fire) wr_d = wr_q + PTR_W'(1);
         if (pop_fire)  rd_d = rd_q + PTR_W'(1);
      end
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
      end
   end

   // Entry storage; contents after reset are hidden by output masking.
   always_ff @(posedge clk) begin
      if (!rst && !squash && push_fire) begin
         pc_q[wr_idx]       <= push_pc;
         mask_q[wr_idx]     <= push_excp ? LANE0_ONLY : push_lane_mask;
         excp_q[wr_idx]     <= push_excp;
         excp_num_q[wr_idx] <= push_excp_num;
      end
   end

   if_lane_pc_expand #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_lane_pc_expand (
      .base_pc_i    (pc_q[rd_idx]),
      .lane_mask_i  (mask_q[rd_idx]),
      .lane_pc_o    (lane_pc),
      .lane_valid_o (lane_valid)
   );

   // Head data is zeroed while empty so stale storage never leaks out.
   assign pop_pc         = pop_valid ? lane_pc            : '0;
   assign pop_lane_valid = pop_valid ? lane_valid         : '0;
   assign pop_excp       = pop_valid ? excp_q[rd_idx]     : 1'b0;
   assign pop_excp_num   = pop_valid ? excp_num_q[rd_idx] : '0;

endmodule : if_pc_queue
`default_nettype wire

// File: tb/tb_if_pc_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_pc_queue                                                       |
// | Self-checking bench: per-cycle vector table plus wrap/stall scripts. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_if_pc_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] push_pc;
   logic [1:0]  push_lane_mask;
   logic        push_excp;
   logic [3:0]  push_excp_num;
   logic        pop_valid;
   logic        pop_ready;
   logic [63:0] pop_pc;
   logic [1:0]  pop_lane_valid;
   logic        pop_excp;
   logic [3:0]  pop_excp_num;
   logic        branch_flag_i, flush, excp_flush, ertn_flush;
   logic        stall;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   if_pc_queue #(
      .DEPTH(4), .FETCH_WIDTH(2), .ADDR_WIDTH(32), .EXCP_NUM_WIDTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
      .push_lane_mask(push_lane_mask), .push_excp(push_excp), .push_excp_num(push_excp_num),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_pc(pop_pc),
      .pop_lane_valid(pop_lane_valid), .pop_excp(pop_excp), .pop_excp_num(pop_excp_num),
      .branch_flag_i(branch_flag_i), .flush(flush), .excp_flush(excp_flush),
      .ertn_flush(ertn_flush), .stall(stall), .count(count)
   );

   // One cycle of stimulus and the state expected right after its edge.
   typedef struct {
      logic        rst, pv;
      logic [31:0] pc;
      logic [1:0]  mask;
      logic        ex;
      logic [3:0]  exn;
      logic        pr, st;
      logic [3:0]  sq;
      logic [2:0]  e_cnt;
      logic        e_vld, e_rdy;
      logic [31:0] e_pc0, e_pc1;
      logic [1:0]  e_lv;
      logic        e_ex;
      logic [3:0]  e_exn;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      logic r, logic pv, logic [31:0] pc, logic [1:0] mask, logic ex, logic [3:0] exn,
      logic pr, logic st, logic [3:0] sq,
      logic [2:0] cnt, logic vld, logic rdy, logic [31:0] pc0, logic [31:0] pc1,
      logic [1:0] lv, logic eex, logic [3:0] eexn);
      vec_t v;
      v.rst = r; v.pv = pv; v.pc = pc; v.mask = mask; v.ex = ex; v.exn = exn;
      v.pr = pr; v.st = st; v.sq = sq;
      v.e_cnt = cnt; v.e_vld = vld; v.e_rdy = rdy; v.e_pc0 = pc0; v.e_pc1 = pc1;
      v.e_lv = lv; v.e_ex = eex; v.e_exn = eexn;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic pv, input logic [31:0] pc,
                        input logic [1:0] mask, input logic ex, input logic [3:0] exn,
                        input logic pr, input logic st, input logic [3:0] sq);
      rst = r; push_valid = pv; push_pc = pc; push_lane_mask = mask;
      push_excp = ex; push_excp_num = exn; pop_ready = pr; stall = st;
      branch_flag_i = sq[0]; flush = sq[1]; excp_flush = sq[2]; ertn_flush = sq[3];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [2:0] cnt, input logic vld,
                             input logic [31:0] pc0);
      check({tag, ".count"}, 64'(count), 64'(cnt));
      check({tag, ".pop_valid"}, 64'(pop_valid), 64'(vld));
      check({tag, ".pop_pc0"}, 64'(pop_pc[31:0]), 64'(pc0));
   endtask

   logic [31:0] model[$];
   logic [31:0] nxt;

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset and idle
      tbl.push_back(mk(1,0,32'h0,2'b00,0,4'h0,0,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      tbl.push_back(mk(1,0,32'h0,2'b00,0,4'h0,0,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,0,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      // Single push then pop
      tbl.push_back(mk(0,1,32'h1c000000,2'b11,0,4'h0,0,0,4'h0, 1,1,1,32'h1c000000,32'h1c000004,2'b11,0,4'h0));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      // Fill to full
      tbl.push_back(mk(0,1,32'h100,2'b11,0,4'h0,0,0,4'h0, 1,1,1,32'h100,32'h104,2'b11,0,4'h0));
      tbl.push_back(mk(0,1,32'h108,2'b11,0,4'h0,0,0,4'h0, 2,1,1,32'h100,32'h104,2'b11,0,4'h0));
      tbl.push_back(mk(0,1,32'h110,2'b11,0,4'h0,0,0,4'h0, 3,1,1,32'h100,32'h104,2'b11,0,4'h0));
      tbl.push_back(mk(0,1,32'h118,2'b11,0,4'h0,0,0,4'h0, 4,1,0,32'h100,32'h104,2'b11,0,4'h0));
      // Push while full is refused even though a pop fires
      tbl.push_back(mk(0,1,32'h120,2'b11,0,4'h0,1,0,4'h0, 3,1,1,32'h108,32'h10c,2'b11,0,4'h0));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 2,1,1,32'h110,32'h114,2'b11,0,4'h0));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 1,1,1,32'h118,32'h11c,2'b11,0,4'h0));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      // Exception group: lane mask forced to lane 0
      tbl.push_back(mk(0,1,32'h200,2'b11,1,4'h8,0,0,4'h0, 1,1,1,32'h200,32'h204,2'b01,1,4'h8));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      // Lane PC carry wraps past the top of the address space
      tbl.push_back(mk(0,1,32'hfffffffc,2'b10,0,4'h3,0,0,4'h0, 1,1,1,32'hfffffffc,32'h0,2'b10,0,4'h3));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      // Each squash source with a concurrent push and pop
      for (int s = 0; s < 4; s++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'(s) * 32'h100;
         tbl.push_back(mk(0,1,a,     2'b11,0,4'h0,0,0,4'h0, 1,1,1,a,a+32'd4,2'b11,0,4'h0));
         tbl.push_back(mk(0,1,a+32'd8, 2'b11,0,4'h0,0,0,4'h0, 2,1,1,a,a+32'd4,2'b11,0,4'h0));
         tbl.push_back(mk(0,1,a+32'd16,2'b11,0,4'h0,0,0,4'h0, 3,1,1,a,a+32'd4,2'b11,0,4'h0));
         tbl.push_back(mk(0,1,a+32'd24,2'b11,0,4'h0,1,0,4'(1 << s), 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
         tbl.push_back(mk(0,1,a+32'd32,2'b11,0,4'h0,0,0,4'h0, 1,1,1,a+32'd32,a+32'd36,2'b11,0,4'h0));
         tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,1,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      end
      // Reset mid-stream discards contents and a concurrent push
      tbl.push_back(mk(0,1,32'h300,2'b11,0,4'h0,0,0,4'h0, 1,1,1,32'h300,32'h304,2'b11,0,4'h0));
      tbl.push_back(mk(1,1,32'h308,2'b11,0,4'h0,0,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));
      tbl.push_back(mk(0,0,32'h0,2'b00,0,4'h0,0,0,4'h0, 0,0,1,32'h0,32'h0,2'b00,0,4'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         string t;
         t = $sformatf("v%0d", i);
         drive(tbl[i].rst, tbl[i].pv, tbl[i].pc, tbl[i].mask, tbl[i].ex, tbl[i].exn,
               tbl[i].pr, tbl[i].st, tbl[i].sq);
         step();
         check({t, ".count"},      64'(count),          64'(tbl[i].e_cnt));
         check({t, ".pop_valid"},  64'(pop_valid),      64'(tbl[i].e_vld));
         check({t, ".push_ready"}, 64'(push_ready),     64'(tbl[i].e_rdy));
         check({t, ".pop_pc0"},    64'(pop_pc[31:0]),   64'(tbl[i].e_pc0));
         check({t, ".pop_pc1"},    64'(pop_pc[63:32]),  64'(tbl[i].e_pc1));
         check({t, ".lane_valid"}, 64'(pop_lane_valid), 64'(tbl[i].e_lv));
         check({t, ".pop_excp"},   64'(pop_excp),       64'(tbl[i].e_ex));
         check({t, ".excp_num"},   64'(pop_excp_num),   64'(tbl[i].e_exn));
      end

      // Wrap: two queued, then six push+pop pairs, then drain; order via a small model
      nxt = 32'h400;
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, nxt, 2'b11, 0, 0, 0, 0, 0);
         model.push_back(nxt);
         nxt += 32'd8;
         step();
         check_head($sformatf("wrap_fill%0d", i), 3'(model.size()), 1'b1, model[0]);
      end
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, nxt, 2'b11, 0, 0, 1, 0, 0);
         void'(model.pop_front());
         model.push_back(nxt);
         nxt += 32'd8;
         step();
         check_head($sformatf("wrap_pair%0d", i), 3'd2, 1'b1, model[0]);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
         void'(model.pop_front());
         step();
         check_head($sformatf("wrap_drain%0d", i), 3'(model.size()),
                    model.size() != 0, (model.size() != 0) ? model[0] : 32'h0);
      end

      // Stall holds the head while pushes still land
      drive(0, 1, 32'h500, 2'b11, 0, 0, 0, 0, 0);
      step();
      drive(0, 1, 32'h508, 2'b11, 0, 0, 0, 0, 0);
      step();
      check_head("stall_pre", 3'd2, 1'b1, 32'h500);
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step();
      check_head("stall_c0", 3'd2, 1'b1, 32'h500);
      drive(0, 1, 32'h510, 2'b11, 0, 0, 1, 1, 0);
      step();
      check_head("stall_c1", 3'd3, 1'b1, 32'h500);
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step();
      check_head("stall_c2", 3'd3, 1'b1, 32'h500);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step();
      check_head("stall_release", 3'd2, 1'b1, 32'h508);
      step();
      check_head("stall_drain0", 3'd1, 1'b1, 32'h510);
      step();
      check_head("stall_drain1", 3'd0, 1'b0, 32'h0);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_if_pc_queue
`default_nettype wire

// File: doc/if_pc_queue.md
# if_pc_queue

Parametrised fetch-stage PC/exception queue that keeps fetch-group PCs, lane valids and fetch exceptions aligned with the instruction data returning from the I-cache. It replaces the single-entry fetch buffer with a DEPTH-entry circular FIFO of FETCH_WIDTH-wide fetch groups. It sits between the PC generator (push side) and the instruction-align/decode handoff (pop side), with branch, flush, exception and ertn squash and a decode-side stall.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- FETCH_WIDTH, 2: instructions per fetch group; power of two, ≥1.
- ADDR_WIDTH, 32: PC width.
- EXCP_NUM_WIDTH, 4: exception code width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- push_valid  in  1  fetch group offered.
- push_ready  out  1  queue can accept; equals !full.
- push_pc  in  ADDR_WIDTH  group base PC, word aligned.
- push_lane_mask  in  FETCH_WIDTH  per-lane valid.
- push_excp  in  1  fetch exception for the group.
- push_excp_num  in  EXCP_NUM_WIDTH  exception code.
- pop_valid  out  1  head entry present.
- pop_ready  in  1  consumer accepts head.
- pop_pc  out  FETCH_WIDTH*ADDR_WIDTH  lane PCs, lane k in bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- pop_lane_valid  out  FETCH_WIDTH  per-lane valid of head.
- pop_excp  out  1  head exception flag.
- pop_excp_num  out  EXCP_NUM_WIDTH  head exception code.
- branch_flag_i  in  1  branch redirect squash.
- flush  in  1  pipeline flush.
- excp_flush  in  1  exception flush.
- ertn_flush  in  1  ertn flush.
- stall  in  1  downstream stall; blocks pop.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH entries of {base_pc, lane_mask, excp, excp_num}. Read/write pointers are $clog2(DEPTH)+1 bits wide with a wrap bit.
  - empty = (rd == wr).
  - full = indices equal and wrap bits differ.
- push_fire = push_valid & push_ready. It writes entry[wr] and increments wr.
- pop_fire = pop_valid & pop_ready & !stall. It increments rd.
- Lane PCs: pop_pc lane k = base_pc + 4*k, computed combinationally from the head. Carry beyond ADDR_WIDTH is discarded.
- Exception entries: when push_excp=1, the stored lane_mask is forced to lane 0 only (1 in bit 0, zeros elsewhere). A faulting group presents exactly one instruction.
- Squash: squash = branch_flag_i | flush | excp_flush | ertn_flush.
  - On squash, rd and wr are both cleared to 0 next cycle.
  - A push_fire or pop_fire in the same cycle is discarded; no entry is written and no pointer advances beyond the clear.
- Priority: rst > squash > stall/normal.
- Simultaneous push_fire and pop_fire: both take effect and count is unchanged.
  - Full: push_ready=0 even if a pop fires that cycle. There is no combinational ready path.
  - Empty: pop_valid=0. There is no same-cycle bypass.
- Outputs while empty:
  - pop_pc, pop_lane_valid, pop_excp and pop_excp_num are all 0.
  - Head data is masked by pop_valid.
- stall holds the head and has no effect on push.

## Timing
- Reset values, next clk after rst=1:
  - pointers 0, count 0, pop_valid 0, push_ready 1.
  - pop_* outputs all 0.
  - Storage contents are don't-care, hidden by the output masking.
- Latency: a group pushed at edge t is presented on pop_valid after edge t (one cycle).
- Squash asserted in cycle t: after edge t the queue is empty, pop_valid=0, push_ready=1. A push in cycle t+1 is accepted normally.
- Pointer wrap: after index DEPTH-1 the index returns to 0 and the wrap bit toggles. FIFO order is preserved across wrap.
- count = wr - rd, modulo 2^(ptr width). It is registered-derived and reflects state after the last edge.
- rst mid-stream: identical to squash and additionally forces reset values.

## Structure
- Shared package (extend defines): IF_QUEUE_DEPTH and FETCH_WIDTH defaults, and a fetch-group entry struct/macro {pc, lane_mask, excp, excp_num}.
- The pointer logic and storage are one flat module.
- One natural sub-module, if_lane_pc_expand: combinational base_pc and mask to per-lane PCs. It is reused by the predecode stage.

## Test plan
- Reset then idle: rst=1 for 2 cycles → count=0, pop_valid=0, push_ready=1, pop_pc=0.
- Push PC 0x1c000000, mask 2'b11, then pop with pop_ready=1:
  - pop_valid one cycle later, pop_pc lanes 0x1c000000 / 0x1c000004.
  - pop_lane_valid=2'b11, then empty.
- Fill DEPTH=4 entries (0x100, 0x108, 0x110, 0x118) with pop_ready=0:
  - push_ready=0, count=4.
  - Push+pop in the same cycle while full is rejected.
  - Drain returns the four PCs in order.
  - Then 6 push/pop pairs across wrap preserve order.
- Push with push_excp=1, excp_num=4'h8, mask 2'b11 → popped entry has pop_lane_valid=2'b01, pop_excp=1, pop_excp_num=4'h8.
- Three entries queued, then each of branch_flag_i / flush / excp_flush / ertn_flush pulsed for one cycle together with push_valid=1 and pop_ready=1:
  - Next cycle count=0, pop_valid=0, and the concurrently pushed group is absent.
- stall=1 with pop_ready=1 on a 2-entry queue → head and count held for all stall cycles. The entry pops on the first cycle stall=0.
